// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin scheduler around a 32-bit shifter.
// Define SHIFT_BYPASS_EN to send amt==0 requests straight to RESP (latency 1).
module shift_sched #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_amt,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_amt,
    input  logic [1:0]  req1_op,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    input  logic        resp_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_id;
    logic        r_resp_id;
    logic [31:0] r_a;
    logic [4:0]  r_amt;
    logic [1:0]  r_op;
    logic [31:0] r_data;

    logic        w_any;
    logic        w_gid;
    logic        w_take;
    logic [31:0] w_sel_a;
    logic [4:0]  w_sel_amt;
    logic [1:0]  w_sel_op;
    logic [31:0] w_rev_in;
    logic [31:0] w_rev_sh;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_result;

    // On contention the requester not granted last wins.
    assign w_any      = req0_valid | req1_valid;
    assign w_gid      = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_take     = (r_state == IDLE) & ~reset & w_any;
    assign req0_ready = w_take & ~w_gid;
    assign req1_ready = w_take & w_gid;

    assign w_sel_a    = w_gid ? req1_a   : req0_a;
    assign w_sel_amt  = w_gid ? req1_amt : req0_amt;
    assign w_sel_op   = w_gid ? req1_op  : req0_op;

    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_data;
    assign busy       = (r_state != IDLE);

    always_comb begin
        w_rev_in = '0;
        w_sll    = '0;
        for (int i = 0; i < 32; i++) begin
            w_rev_in[i] = r_a[31-i];
        end
        w_rev_sh = w_rev_in >> r_amt;
        for (int i = 0; i < 32; i++) begin
            w_sll[i] = w_rev_sh[31-i];
        end
        w_srl = r_a >> r_amt;
        w_sra = $unsigned($signed(r_a) >>> r_amt);
        case (r_op)
            2'b01:   w_result = w_sll;
            2'b10:   w_result = w_sra;
            default: w_result = w_srl;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_take) begin
`ifdef SHIFT_BYPASS_EN
                    w_next = (w_sel_amt == 5'd0) ? RESP : EXEC;
`else
                    w_next = EXEC;
`endif
                end
            end
            EXEC:    w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last    <= ~RR_INIT;
            r_id      <= 1'b0;
            r_resp_id <= 1'b0;
            r_a       <= '0;
            r_amt     <= '0;
            r_op      <= '0;
            r_data    <= '0;
        end else begin
            if (w_take) begin
                r_last <= w_gid;
                r_id   <= w_gid;
                r_a    <= w_sel_a;
                r_amt  <= w_sel_amt;
                r_op   <= w_sel_op;
`ifdef SHIFT_BYPASS_EN
                if (w_sel_amt == 5'd0) begin
                    r_data    <= w_sel_a;
                    r_resp_id <= w_gid;
                end
`endif
            end
            if (r_state == EXEC) begin
                r_data    <= w_result;
                r_resp_id <= r_id;
            end
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed cases plus a randomized
// run against a cycle-level reference model.
module tb_shift_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_amt;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a;
    logic [4:0]  req1_amt;
    logic [1:0]  req1_op;
    logic        resp_valid, resp_id, resp_ready, busy;
    logic [31:0] resp_data;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef SHIFT_BYPASS_EN
    localparam int LAT0 = 1;
`else
    localparam int LAT0 = 2;
`endif

    shift_sched #(.RR_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_amt(req1_amt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                              input logic [4:0] amt,
                                              input logic [1:0] op);
        logic [63:0] ext;
        case (op)
            2'b01: return a << amt;
            2'b10: begin
                ext = {{32{a[31]}}, a} >> amt;
                return ext[31:0];
            end
            default: return a >> amt;
        endcase
    endfunction

    task automatic clear_reqs();
        req0_valid = 0; req0_a = '0; req0_amt = '0; req0_op = '0;
        req1_valid = 0; req1_a = '0; req1_amt = '0; req1_op = '0;
    endtask

    task automatic set_req(input bit id, input logic [31:0] a,
                           input logic [4:0] amt, input logic [1:0] op);
        if (id) begin
            req1_valid = 1; req1_a = a; req1_amt = amt; req1_op = op;
        end else begin
            req0_valid = 1; req0_a = a; req0_amt = amt; req0_op = op;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_reqs();
        resp_ready = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    // Drives one request, waits for accept and response, then handshakes.
    task automatic issue(input bit id, input logic [31:0] a,
                         input logic [4:0] amt, input logic [1:0] op,
                         output logic gid, output logic [31:0] data,
                         output int lat, output bit tmo);
        int n;
        tmo = 0; lat = 0; gid = 0; data = '0;
        @(negedge clk);
        set_req(id, a, amt, op);
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready)) begin
            n++;
            if (n > 20) begin
                tmo = 1; clear_reqs(); return;
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        clear_reqs();
        #1;
        lat = 1;
        while (!resp_valid) begin
            if (lat > 20) begin
                tmo = 1; return;
            end
            @(negedge clk); #1;
            lat++;
        end
        gid = resp_id;
        data = resp_data;
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        resp_ready = 0;
        clear_reqs();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk); #1;
        n_chk++;
        if ({req0_ready, req1_ready, resp_valid, busy, resp_id} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got r0=%b r1=%b v=%b busy=%b id=%b want all 0",
                     req0_ready, req1_ready, resp_valid, busy, resp_id);
        end
        n_chk++;
        if (resp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", resp_data);
        end
        clear_reqs();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_directed();
        logic [31:0] a_t[6];
        logic [4:0]  amt_t[6];
        logic [1:0]  op_t[6];
        logic [31:0] exp_t[6];
        bit          id_t[6];
        logic        gid;
        logic [31:0] d;
        int          lat;
        bit          tmo;
        a_t   = '{32'h80000000, 32'hF0000000, 32'h00000001,
                  32'h00000010, 32'hFFFFFFFF, 32'h7FFFFFFF};
        amt_t = '{5'd4, 5'd31, 5'd31, 5'd4, 5'd31, 5'd31};
        op_t  = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
        exp_t = '{32'h08000000, 32'hFFFFFFFF, 32'h80000000,
                  32'h00000001, 32'h00000001, 32'h00000000};
        id_t  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            issue(id_t[i], a_t[i], amt_t[i], op_t[i], gid, d, lat, tmo);
            n_chk++;
            if (tmo !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_timeout got timeout want response", i);
                continue;
            end
            n_chk++;
            if (d !== exp_t[i] || gid !== id_t[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result got %h id %b want %h id %b",
                         i, d, gid, exp_t[i], id_t[i]);
            end
            n_chk++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL dir%0d_latency got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_round_robin();
        logic        exp_g;
        logic        prev_rdy;
        logic        last_g;
        logic [31:0] exp_d;
        int          grants;
        do_reset();
        exp_g = 0; prev_rdy = 0; last_g = 0; grants = 0;
        @(negedge clk);
        set_req(0, 32'hA5A50000, 5'd8, 2'b00);
        set_req(1, 32'h000000F0, 5'd4, 2'b01);
        resp_ready = 1;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (req0_ready || req1_ready) begin
                n_chk++;
                if (req0_ready === req1_ready || req1_ready !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_grant cyc %0d got r0=%b r1=%b want grant %b",
                             c, req0_ready, req1_ready, exp_g);
                end
                n_chk++;
                if (prev_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_pulse cyc %0d got ready high 2 cycles want 1", c);
                end
                last_g = exp_g;
                exp_g = ~exp_g;
                grants++;
            end
            if (resp_valid) begin
                exp_d = last_g ? 32'h00000F00 : 32'h00A5A500;
                n_chk++;
                if (resp_id !== last_g || resp_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL rr_resp got id %b %h want id %b %h",
                             resp_id, resp_data, last_g, exp_d);
                end
            end
            prev_rdy = req0_ready | req1_ready;
            @(negedge clk);
        end
        n_chk++;
        if (grants < 5) begin
            n_fail++;
            $display("FAIL rr_count got %0d grants want >= 5", grants);
        end
        clear_reqs();
        repeat (4) @(negedge clk);
        resp_ready = 0;
    endtask

    task automatic test_backpressure();
        int          n;
        logic [31:0] exp_d;
        exp_d = 32'h02468ACF;
        do_reset();
        set_req(0, 32'h12345678, 5'd3, 2'b10);
        #1;
        n_chk++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept got r0=%b want 1", req0_ready);
        end
        @(negedge clk);
        set_req(1, 32'hFFFFFFFF, 5'd1, 2'b00);
        #1;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== exp_d) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d got v=%b id=%b %h want v=1 id=0 %h",
                         c, resp_valid, resp_id, resp_data, exp_d);
            end
            n_chk++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_noready cyc %0d got r0=%b r1=%b want 0 0",
                         c, req0_ready, req1_ready);
            end
            @(negedge clk); #1;
        end
        resp_ready = 1;
        @(negedge clk); #1;
        resp_ready = 0;
        n_chk++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== exp_d) begin
            n_fail++;
            $display("FAIL bp_release got busy=%b v=%b %h want 0 0 %h",
                     busy, resp_valid, resp_data, exp_d);
        end
        n_chk++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_grant got r0=%b r1=%b want 0 1",
                     req0_ready, req1_ready);
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        set_req(1, 32'hFFFF0000, 5'd8, 2'b01);
        #1;
        while (!req1_ready) begin
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_exec got busy=%b want 1", busy);
        end
        set_req(0, 32'h1, 5'd1, 2'b00);
        reset = 1;
        #1;
        n_chk++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_clear got v=%b busy=%b %h want 0 0 0",
                     resp_valid, busy, resp_data);
        end
        @(negedge clk); #1;
        n_chk++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ready got r0=%b r1=%b want 0 0",
                     req0_ready, req1_ready);
        end
        clear_reqs();
        reset = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (resp_valid) seen++;
        end
        n_chk++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_noresp got %0d valid cycles want 0", seen);
        end
        set_req(0, 32'h0, 5'd0, 2'b00);
        set_req(1, 32'h0, 5'd0, 2'b00);
        #1;
        n_chk++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_prio got r0=%b r1=%b want 1 0",
                     req0_ready, req1_ready);
        end
        clear_reqs();
    endtask

    task automatic test_amt0();
        logic        gid;
        logic [31:0] d;
        int          lat;
        bit          tmo;
        issue(0, 32'hDEADBEEF, 5'd0, 2'b10, gid, d, lat, tmo);
        n_chk++;
        if (tmo !== 1'b0 || d !== 32'hDEADBEEF || lat !== LAT0) begin
            n_fail++;
            $display("FAIL amt0_a got %h lat %0d tmo %b want %h lat %0d",
                     d, lat, tmo, 32'hDEADBEEF, LAT0);
        end
        issue(1, 32'h80000001, 5'd0, 2'b01, gid, d, lat, tmo);
        n_chk++;
        if (tmo !== 1'b0 || d !== 32'h80000001 || lat !== LAT0 || gid !== 1'b1) begin
            n_fail++;
            $display("FAIL amt0_b got %h id %b lat %0d want %h id 1 lat %0d",
                     d, gid, lat, 32'h80000001, LAT0);
        end
    endtask

    task automatic test_random();
        bit          m_pend, m_last, m_id, e_v, e_g, e_r0, e_r1, idle;
        int          m_wait;
        logic [31:0] m_data;
        do_reset();
        m_pend = 0; m_wait = 0; m_last = 1; m_id = 0; m_data = '0;
        repeat (400) begin
            @(negedge clk);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = $urandom; req1_a = $urandom;
            req0_amt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            req1_amt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            req0_op = 2'($urandom); req1_op = 2'($urandom);
            resp_ready = ($urandom_range(0, 1) != 0);
            if (m_pend && m_wait > 0) m_wait--;
            #1;
            idle = !m_pend;
            e_g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e_r0 = idle && (req0_valid || req1_valid) && !e_g;
            e_r1 = idle && (req0_valid || req1_valid) && e_g;
            e_v  = m_pend && (m_wait == 0);
            n_chk++;
            if (req0_ready !== e_r0 || req1_ready !== e_r1 ||
                resp_valid !== e_v || busy !== m_pend) begin
                n_fail++;
                $display("FAIL rand_ctrl got r0=%b r1=%b v=%b busy=%b want %b %b %b %b",
                         req0_ready, req1_ready, resp_valid, busy,
                         e_r0, e_r1, e_v, m_pend);
            end
            if (e_v) begin
                n_chk++;
                if (resp_id !== m_id || resp_data !== m_data) begin
                    n_fail++;
                    $display("FAIL rand_data got id %b %h want id %b %h",
                             resp_id, resp_data, m_id, m_data);
                end
            end
            if (e_v && resp_ready) begin
                m_pend = 0;
            end else if (idle && (req0_valid || req1_valid)) begin
                m_pend = 1;
                m_last = e_g;
                m_id   = e_g;
                if (e_g) begin
                    m_data = ref_shift(req1_a, req1_amt, req1_op);
                    m_wait = (req1_amt == 0) ? LAT0 : 2;
                end else begin
                    m_data = ref_shift(req0_a, req0_amt, req0_op);
                    m_wait = (req0_amt == 0) ? LAT0 : 2;
                end
            end
        end
        @(negedge clk);
        clear_reqs();
        resp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_amt0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 SHALL have parameter RR_INIT, default 0: the requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a shift request.
REQ-005 SHALL have port req0_ready  output  1  requester 0 request accepted this cycle.
REQ-006 SHALL have port req0_a  input  32  requester 0 operand.
REQ-007 SHALL have port req0_amt  input  5  requester 0 shift amount.
REQ-008 SHALL have port req0_op  input  2  requester 0 operation: 00 SRL, 01 SLL, 10 SRA, 11 reserved.
REQ-009 SHALL have ports req1_valid, req1_ready, req1_a, req1_amt, req1_op, identical to requester 0 but for requester 1.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_id  output  1  requester that owns the result.
REQ-012 SHALL have port resp_data  output  32  shift result.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-016 SHALL, in IDLE, grant the single valid requester; when both are valid, SHALL grant the requester that was not granted last (round-robin).
REQ-017 SHALL drive reqN_ready combinationally high only in IDLE and only for the granted requester; the request transfers when valid and ready are both high.
REQ-018 SHALL, on transfer, register a, amt, op and id, update last_grant, and move to EXEC.
REQ-019 SHALL, in EXEC, compute the result into the resp_data register and move to RESP in one cycle; resp_valid rises two cycles after the accept edge.
REQ-020 SHALL compute SRL as a zero-fill logical right shift by amt.
REQ-021 SHALL compute SLL as bit-reverse, then logical right shift, then bit-reverse (zero-fill from bit 0).
REQ-022 SHALL compute SRA as a right shift that fills with a[31].
REQ-023 SHALL treat op 11 as SRL.
REQ-024 SHALL return a unchanged when amt is 0; amt 31 SHALL leave bit 0 only for SRL, bit 31 only for SLL, and all bits equal to a[31] for SRA.
REQ-025 SHALL, in RESP, hold resp_valid, resp_id and resp_data stable until resp_ready is high; on that edge SHALL return to IDLE.
REQ-026 SHALL keep req0_ready and req1_ready low in EXEC and RESP; a new request is accepted no earlier than the cycle after the response handshake.
REQ-027 SHALL ignore requester inputs that change while the request is not yet accepted, and SHALL accept no partial transfer.
REQ-028 SHALL keep resp_data holding the last result after a handshake; resp_valid SHALL be low.

Reset
REQ-029 SHALL, on reset (asynchronous, including mid-operation): state IDLE, resp_valid 0, resp_id 0, resp_data 0, busy 0, last_grant set so that RR_INIT has priority; any captured request SHALL be discarded.
REQ-030 SHALL keep reqN_ready low while reset is high.

Configuration
REQ-031 SHALL, when macro SHIFT_BYPASS_EN is defined, send an accepted request with amt equal to 0 directly from IDLE to RESP with resp_data equal to a, giving a latency of 1 cycle.
REQ-032 SHALL, without SHIFT_BYPASS_EN, pass every request, including amt 0, through EXEC with a latency of 2 cycles.

Verification
REQ-033 SHALL cover: req0 SRL a=0x80000000, amt=4 -> resp_data=0x08000000, resp_id=0, resp_valid 2 cycles after accept.
REQ-034 SHALL cover: req1 SRA a=0xF0000000, amt=31 -> 0xFFFFFFFF; SLL a=0x00000001, amt=31 -> 0x80000000; op 11 a=0x10, amt=4 -> 0x1.
REQ-035 SHALL cover: both requesters valid continuously with RR_INIT=0 -> grants alternate 0,1,0,1 and each req_ready is a 1-cycle pulse.
REQ-036 SHALL cover: resp_ready held low for 5 cycles -> resp_valid, resp_id and resp_data stable, no ready asserted; release -> IDLE on the next cycle.
REQ-037 SHALL cover: reset asserted during EXEC -> resp_valid, busy and resp_data immediately 0, no response issued; amt=0 request -> latency 1 with SHIFT_BYPASS_EN defined, latency 2 without.
